// File: rtl/reg_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module      : reg_fifo_pkg
// Description : Shared sizing defaults for the register-based memory blocks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_fifo_pkg;

    // Default geometry, reused by later memory-group blocks
    localparam int FIFO_DEFAULT_DEPTH  = 8;
    localparam int FIFO_DEFAULT_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/fifo_storage.sv
//------------------------------------------------------------------------------
// Module      : fifo_storage
// Description : DEPTH x DATA_W flip-flop register array with one synchronous
//               write port and one combinational read port. Contents are not
//               reset; they are don't-care until written.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_storage
    import reg_fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DEFAULT_DATA_W,
    parameter  int DEPTH  = FIFO_DEFAULT_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write the addressed entry on an accepted push; no reset on the array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/reg_fifo.sv
//------------------------------------------------------------------------------
// Module      : reg_fifo
// Description : Single-clock FIFO built on a flip-flop register array.
//               Registered read data (one-cycle latency), occupancy count,
//               full/empty flags and one-cycle overflow/underflow pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DEFAULT_DATA_W,
    parameter  int DEPTH  = FIFO_DEFAULT_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0]   c_depth_cnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one   = AW'(1);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_mem_rdata;

    // Flags come from the registered count, which also resolves ptr equality
    assign w_full  = (r_count == c_depth_cnt);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still taken when a read frees a slot in the
    // same cycle; a read of an empty FIFO is never taken (no bypass path).
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    fifo_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .clk    (clk),
        .wr_en  (w_wr_acc),
        .waddr  (r_wr_ptr),
        .wdata  (wr_data),
        .raddr  (r_rd_ptr),
        .rdata  (w_mem_rdata)
    );

    // Pointer advance; power-of-two depth makes the wrap a natural rollover
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Occupancy tracking: simultaneous push and pop cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: rd_data holds until the next accepted pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_mem_rdata;
            end
        end
    end

    // Single-cycle error pulses for rejected requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en & ~w_wr_acc;
            r_underflow <= rd_en & ~w_rd_acc;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_reg_fifo.sv
//------------------------------------------------------------------------------
// Module      : tb_reg_fifo
// Description : Directed self-checking bench for reg_fifo (DEPTH=8, DATA_W=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int errors;
    int checks;

    reg_fifo #(
        .DATA_W (8),
        .DEPTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
    endtask

    // Directed sequence
    initial begin
        errors = 0;
        checks = 0;
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_empty", empty, 1);
            check("idle_full", full, 0);
            check("idle_count", count, 0);
            check("idle_rd_data", rd_data, 8'h00);
            check("idle_rd_valid", rd_valid, 0);
            check("idle_overflow", overflow, 0);
            check("idle_underflow", underflow, 0);
        end

        // Three writes then three reads
        drive(1'b1, 8'h11, 1'b0); tick(); check("w3_count1", count, 1);
        check("w3_not_empty", empty, 0);
        drive(1'b1, 8'h22, 1'b0); tick(); check("w3_count2", count, 2);
        drive(1'b1, 8'h33, 1'b0); tick(); check("w3_count3", count, 3);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("r3_data0", rd_data, 8'h11); check("r3_valid0", rd_valid, 1); check("r3_count2", count, 2);
        tick();
        check("r3_data1", rd_data, 8'h22); check("r3_valid1", rd_valid, 1); check("r3_count1", count, 1);
        tick();
        check("r3_data2", rd_data, 8'h33); check("r3_valid2", rd_valid, 1); check("r3_count0", count, 0);
        check("r3_empty", empty, 1);
        drive(1'b0, 8'h00, 1'b0); tick();
        check("r3_valid_drop", rd_valid, 0);
        check("r3_data_hold", rd_data, 8'h33);
        check("r3_no_underflow", underflow, 0);

        // Fill to full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0);
            tick();
            check("fill_count", count, i + 1);
        end
        check("fill_full", full, 1);
        check("fill_no_overflow", overflow, 0);

        // Rejected write while full
        drive(1'b1, 8'hFF, 1'b0); tick();
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_full", full, 1);
        drive(1'b0, 8'h00, 1'b0); tick();
        check("ovf_pulse_end", overflow, 0);

        // Simultaneous read/write while full
        drive(1'b1, 8'h55, 1'b1); tick();
        check("fullrw_count", count, 8);
        check("fullrw_overflow", overflow, 0);
        check("fullrw_data", rd_data, 8'hA0);
        check("fullrw_valid", rd_valid, 1);

        // Drain: A1..A7 then 55; FF never appears
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            check("drain_data", rd_data, (i < 7) ? (8'hA1 + 8'(i)) : 8'h55);
            check("drain_count", count, 7 - i);
        end
        check("drain_empty", empty, 1);

        // Simultaneous read/write while empty
        drive(1'b1, 8'h77, 1'b1); tick();
        check("emptyrw_underflow", underflow, 1);
        check("emptyrw_valid", rd_valid, 0);
        check("emptyrw_count", count, 1);
        check("emptyrw_data_hold", rd_data, 8'h55);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("emptyrw_read", rd_data, 8'h77);
        check("emptyrw_read_valid", rd_valid, 1);
        check("emptyrw_underflow_end", underflow, 0);
        check("emptyrw_count0", count, 0);

        // Five writes, then a read so rd_valid/rd_data are live before reset
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h01 + 8'(i), 1'b0);
            tick();
        end
        check("pre_rst_count", count, 5);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("pre_rst_data", rd_data, 8'h01);
        check("pre_rst_valid", rd_valid, 1);
        drive(1'b0, 8'h00, 1'b0);

        // 1 ns asynchronous reset pulse mid-cycle
        #3 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_data", rd_data, 8'h00);
        check("arst_valid", rd_valid, 0);
        rst = 1'b0;
        tick();
        check("post_rst_count", count, 0);

        // 12 write/read pairs walk the pointers past the wrap point
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0); tick();
            drive(1'b0, 8'h00, 1'b1); tick();
            check("wrap_data", rd_data, 8'hC0 + 8'(i));
            check("wrap_count", count, 0);
        end

        // Final round-trip
        drive(1'b1, 8'h3C, 1'b0); tick();
        check("final_count", count, 1);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("final_data", rd_data, 8'h3C);
        check("final_valid", rd_valid, 1);
        check("final_empty", empty, 1);
        drive(1'b0, 8'h00, 1'b0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
